spi_mic_apb_fifo: RTL and testbench

Parametrised successor of the team's SPI microphone APB wrapper. Generates its own sample-rate tick and SPI SCLK from PCLK, so no second clock domain is needed. Captures SAMPLE_W-bit frames from an SPI microphone into a DEPTH-entry FIFO and exposes data, status and control over a zero-wait-state APB slave. Raises a level interrupt on a FIFO threshold or on overflow.

---
 rtl/spi_mic_apb_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_spi_mic_apb_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mic_apb_fifo.sv
// SPI microphone capture into a DEPTH-entry FIFO behind a zero-wait-state APB slave.
// Define SPI_MIC_SIGNEXT_EN to sign-extend DATA reads from bit SAMPLE_W-1.
module spi_mic_apb_fifo #(
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH      = 16,
    parameter int SCLK_HALF  = 4,
    parameter int SAMPLE_DIV = 500
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [15:0] PWDATA,
    output logic [15:0] PRDATA,
    output logic        PREADY,
    input  logic        MISO,
    output logic        CS_b,
    output logic        sclk,
    output logic        interrupt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int HW = $clog2(SCLK_HALF + 1);
    localparam int BW = $clog2(2 * SAMPLE_W + 1);
    localparam logic [TW-1:0] DIV_LAST  = TW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SAMPLE_W - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, PUSH} state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [HW-1:0]       half_q, half_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                sclk_q, sclk_d, cs_b_q, cs_b_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                en_q, en_d, irq_en_q, irq_en_d;
    logic [7:0]          thresh_q, thresh_d;
    logic                ovf_q, ovf_d, miss_q, miss_d, irq_q, irq_d;

    logic        tick, push, push_ok, pop, access, rd, wr, empty, full;
    logic [1:0]  sel;
    logic [15:0] head_ext, status;
    logic        unused_ok;

    assign access = PSEL && PENABLE;
    assign rd     = access && !PWRITE;
    assign wr     = access && PWRITE;
    assign sel    = PADDR[3:2];
    assign empty  = (level_q == '0);
    assign full   = (level_q == FULL_LVL);
    assign tick   = en_q && (tick_cnt_q == DIV_LAST);
    assign status = {ovf_q, miss_q, full, empty, 4'b0, 8'(level_q)};
    assign unused_ok = ^{PADDR[1:0], PWDATA[7:2]};

    // Frame sequencer: all phase lengths are counted in PCLK cycles by half_q.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        cs_b_d  = cs_b_q;
        shift_d = shift_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (tick) begin
                state_d = LEAD;
                cs_b_d  = 1'b0;
                half_d  = '0;
            end
            LEAD: if (half_q == HALF_LAST) begin
                state_d = SHIFT;
                half_d  = '0;
                bit_d   = '0;
                sclk_d  = 1'b1;
                shift_d = (shift_q << 1) | SAMPLE_W'(MISO);
            end else half_d = half_q + 1'b1;
            SHIFT: if (half_q == HALF_LAST) begin
                half_d = '0;
                if (bit_q == BIT_LAST) begin
                    state_d = TRAIL;
                    sclk_d  = 1'b0;
                end else begin
                    bit_d  = bit_q + 1'b1;
                    sclk_d = !sclk_q;
                    if (!sclk_q) shift_d = (shift_q << 1) | SAMPLE_W'(MISO);
                end
            end else half_d = half_q + 1'b1;
            TRAIL: if (half_q == HALF_LAST) begin
                state_d = PUSH;
                cs_b_d  = 1'b1;
            end else half_d = half_q + 1'b1;
            PUSH: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    always_comb begin
        tick_cnt_d = (!en_q || tick) ? '0 : tick_cnt_q + 1'b1;
        pop        = rd && (sel == 2'd0) && !empty;
        push_ok    = push && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop) level_d = level_q + 1'b1;
        else if (!push_ok && pop) level_d = level_q - 1'b1;

        en_d     = en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (wr && sel == 2'd2) begin
            en_d     = PWDATA[0];
            irq_en_d = PWDATA[1];
            thresh_d = PWDATA[15:8];
        end
        ovf_d  = ovf_q;
        miss_d = miss_q;
        if (wr && sel == 2'd1 && PWDATA[15]) ovf_d = 1'b0;
        if (wr && sel == 2'd1 && PWDATA[14]) miss_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;
        if (tick && state_q != IDLE) miss_d = 1'b1;

        irq_d = (irq_en_q && thresh_q != 8'd0 &&
                 ({8'd0, level_q} >= {LW'(0), thresh_q})) || ovf_q;
    end

    always_comb begin
        head_ext = 16'(mem_q[rd_ptr_q]);
`ifdef SPI_MIC_SIGNEXT_EN
        for (int i = SAMPLE_W; i < 16; i++) head_ext[i] = mem_q[rd_ptr_q][SAMPLE_W-1];
`endif
        PRDATA = 16'h0;
        if (rd) begin
            case (sel)
                2'd0:    PRDATA = empty ? 16'h0 : head_ext;
                2'd1:    PRDATA = status;
                2'd2:    PRDATA = {thresh_q, 6'b0, irq_en_q, en_q};
                default: PRDATA = 16'h0;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            half_q     <= '0;
            bit_q      <= '0;
            sclk_q     <= 1'b0;
            cs_b_q     <= 1'b1;
            shift_q    <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= '0;
            ovf_q      <= 1'b0;
            miss_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            cs_b_q     <= cs_b_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            ovf_q      <= ovf_d;
            miss_q     <= miss_d;
            irq_q      <= irq_d;
        end
    end

    assign PREADY    = access;
    assign CS_b      = cs_b_q;
    assign sclk      = sclk_q;
    assign interrupt = irq_q;
endmodule

// File: tb/tb_spi_mic_apb_fifo.sv
// Bench for spi_mic_apb_fifo: a MISO model feeds frames, expected samples go through a queue.
`timescale 1ns/1ps
module tb_spi_mic_apb_fifo;
    localparam int SW = 16, DEPTH = 16, HALF = 4, DIV = 200;
    localparam int CS_LOW = (2 * SW + 2) * HALF;

    logic        PCLK = 0, PRESET = 1, PSEL = 0, PSEL12 = 0, PENABLE = 0, PWRITE = 0;
    logic [3:0]  PADDR = 0;
    logic [15:0] PWDATA = 0;
    logic [15:0] PRDATA, PRDATA12;
    logic        PREADY, PREADY12, MISO, MISO12;
    logic        CS_b, sclk, interrupt, cs12, sclk12, irq12;

    int n_pass = 0, n_chk = 0;
    logic [15:0] exp_q [$];

    always #5 PCLK = ~PCLK;

    spi_mic_apb_fifo #(.SAMPLE_W(SW), .DEPTH(DEPTH), .SCLK_HALF(HALF), .SAMPLE_DIV(DIV)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .MISO(MISO),
        .CS_b(CS_b), .sclk(sclk), .interrupt(interrupt));

    spi_mic_apb_fifo #(.SAMPLE_W(12), .DEPTH(4), .SCLK_HALF(2), .SAMPLE_DIV(100)) u12 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL12), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA12), .PREADY(PREADY12), .MISO(MISO12),
        .CS_b(cs12), .sclk(sclk12), .interrupt(irq12));

    // Microphone: new word on CS_b fall, next bit on each sclk fall, MSB first.
    logic [15:0] mic_words [32];
    logic [15:0] cur = 0;
    int fidx = 0, bidx = 0, rise_total = 0, rise12 = 0;
    bit cs_prev = 1;
    assign MISO = cur[bidx];
    always @(negedge CS_b or posedge CS_b or negedge sclk) begin
        if (CS_b !== 1'b0) cs_prev = 1;
        else if (cs_prev) begin
            cur = mic_words[fidx % 32]; fidx++; bidx = SW - 1; cs_prev = 0;
        end else if (bidx > 0) bidx--;
    end
    always @(posedge sclk) rise_total++;
    // 12-bit mic sends 1 then zeros: 0x800.
    always @(posedge sclk12 or posedge cs12) if (cs12) rise12 = 0; else rise12++;
    assign MISO12 = (rise12 == 0);

    function automatic logic [15:0] ext(input logic [15:0] v, input int w);
        logic [15:0] r = v;
`ifdef SPI_MIC_SIGNEXT_EN
        if (v[w-1]) for (int i = w; i < 16; i++) r[i] = 1'b1;
`endif
        return r;
    endfunction

    task automatic apb_write(input bit to12, input logic [3:0] a, input logic [15:0] d);
        @(posedge PCLK); #1;
        if (to12) PSEL12 = 1; else PSEL = 1;
        PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1; PENABLE = 1;
        @(posedge PCLK); #1; PSEL = 0; PSEL12 = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input bit to12, input logic [3:0] a, output logic [15:0] d);
        @(posedge PCLK); #1;
        if (to12) PSEL12 = 1; else PSEL = 1;
        PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1; PENABLE = 1;
        #1 d = to12 ? PRDATA12 : PRDATA;
        @(posedge PCLK); #1; PSEL = 0; PSEL12 = 0; PENABLE = 0;
    endtask

    task automatic wait_cs(input bit main, input logic v, input int lim, input string nm);
        int i = 0;
        while (((main ? CS_b : cs12) !== v) && i < lim) begin @(posedge PCLK); #1; i++; end
        n_chk++;
        if ((main ? CS_b : cs12) !== v) $display("FAIL %s: chip select stuck at %b, want %b", nm, main ? CS_b : cs12, v);
        else n_pass++;
    endtask

    task automatic fill_mic(input int n, input logic [15:0] seed, input int keep);
        logic [15:0] v;
        for (int k = 0; k < n; k++) begin
            v = seed + 16'(k) * 16'h1357;
            mic_words[(fidx + k) % 32] = v;
            if (k < keep) exp_q.push_back(ext(v, SW));
        end
    endtask

    task automatic test_reset();
        n_chk++; if ({CS_b, sclk, interrupt, PREADY, PRDATA} !== {4'b1000, 16'h0}) $display("FAIL reset_idle: got %b%b%b%b %h want 1000 0000", CS_b, sclk, interrupt, PREADY, PRDATA); else n_pass++;
        apb_write(0, 4'h8, 16'h0001);
        wait_cs(1, 0, DIV + 20, "reset_frame_start");
        repeat (20) @(posedge PCLK);
        #1 PRESET = 1;
        #1;
        n_chk++; if ({CS_b, sclk} !== 2'b10) $display("FAIL reset_async: cs/sclk=%b%b want 10", CS_b, sclk); else n_pass++;
        @(posedge PCLK); #1;
        PRESET = 0; PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 4'h4;
        #1;
        n_chk++; if (PRDATA !== 16'h1000) $display("FAIL reset_status: got %h want 1000", PRDATA); else n_pass++;
        n_chk++; if ({CS_b, sclk, interrupt, PREADY} !== 4'b1001) $display("FAIL reset_outs: got %b%b%b%b want 1001", CS_b, sclk, interrupt, PREADY); else n_pass++;
        @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
        exp_q.delete();
    endtask

    task automatic test_frame();
        logic [15:0] d;
        int r0, cnt;
        for (int i = 0; i < 32; i++) mic_words[i] = 16'hA5C3;
        exp_q.push_back(ext(16'hA5C3, SW));
        apb_write(0, 4'h8, 16'h0001);
        wait_cs(1, 0, DIV + 20, "frame_start");
        r0 = rise_total; cnt = 0;
        while (CS_b !== 1'b1 && cnt < 400) begin @(posedge PCLK); #1; cnt++; end
        n_chk++; if (cnt !== CS_LOW) $display("FAIL frame_cs_len: got %0d want %0d", cnt, CS_LOW); else n_pass++;
        n_chk++; if (rise_total - r0 !== SW) $display("FAIL frame_sclk_rises: got %0d want %0d", rise_total - r0, SW); else n_pass++;
        apb_write(0, 4'h8, 16'h0000);
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h0001) $display("FAIL frame_status1: got %h want 0001", d); else n_pass++;
        apb_read(0, 4'h0, d);
        n_chk++; if (d !== exp_q[0]) $display("FAIL frame_data: got %h want %h", d, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h1000) $display("FAIL frame_status0: got %h want 1000", d); else n_pass++;
    endtask

    task automatic test_regs();
        logic [15:0] d;
        apb_write(0, 4'h8, 16'hAB02);
        apb_read(0, 4'h8, d);
        n_chk++; if (d !== 16'hAB02) $display("FAIL regs_ctrl: got %h want ab02", d); else n_pass++;
        apb_write(0, 4'hC, 16'hFFFF);
        apb_read(0, 4'hC, d);
        n_chk++; if (d !== 16'h0000) $display("FAIL regs_c: got %h want 0000", d); else n_pass++;
        apb_read(0, 4'h0, d);
        n_chk++; if (d !== 16'h0000) $display("FAIL regs_empty_data: got %h want 0000", d); else n_pass++;
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h1000) $display("FAIL regs_empty_status: got %h want 1000", d); else n_pass++;
        apb_write(0, 4'h8, 16'h0000);
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        fill_mic(DEPTH + 1, 16'h8A0F, DEPTH);
        apb_write(0, 4'h8, 16'h0001);
        for (int k = 0; k <= DEPTH; k++) begin
            wait_cs(1, 0, DIV + 20, "ovf_start");
            wait_cs(1, 1, CS_LOW + 10, "ovf_end");
        end
        apb_write(0, 4'h8, 16'h0000);
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'hA010) $display("FAIL ovf_status_full: got %h want a010", d); else n_pass++;
        n_chk++; if (interrupt !== 1'b1) $display("FAIL ovf_irq: got %b want 1", interrupt); else n_pass++;
        for (int k = 0; k < DEPTH; k++) begin
            apb_read(0, 4'h0, d);
            n_chk++; if (d !== exp_q[0]) $display("FAIL ovf_data[%0d]: got %h want %h", k, d, exp_q[0]); else n_pass++;
            void'(exp_q.pop_front());
        end
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h9000) $display("FAIL ovf_status_empty: got %h want 9000", d); else n_pass++;
        apb_write(0, 4'h4, 16'h8000);
        n_chk++; if (interrupt !== 1'b1) $display("FAIL ovf_irq_lag: got %b want 1", interrupt); else n_pass++;
        @(posedge PCLK); #1;
        n_chk++; if (interrupt !== 1'b0) $display("FAIL ovf_irq_clear: got %b want 0", interrupt); else n_pass++;
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h1000) $display("FAIL ovf_status_clear: got %h want 1000", d); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] d;
        fill_mic(DEPTH + 1, 16'h3C71, DEPTH + 1);
        apb_write(0, 4'h8, 16'h0001);
        for (int k = 0; k < DEPTH; k++) begin
            wait_cs(1, 0, DIV + 20, "full_start");
            wait_cs(1, 1, CS_LOW + 10, "full_end");
        end
        wait_cs(1, 0, DIV + 20, "full_last_start");
        // Land the DATA access on the cycle the last frame is pushed.
        repeat (CS_LOW - 1) @(posedge PCLK);
        #1 PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 4'h0;
        @(posedge PCLK); #1 PENABLE = 1;
        #1 d = PRDATA;
        n_chk++; if (CS_b !== 1'b1) $display("FAIL full_align: cs=%b want 1", CS_b); else n_pass++;
        n_chk++; if (d !== exp_q[0]) $display("FAIL full_head: got %h want %h", d, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
        apb_write(0, 4'h8, 16'h0000);
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h2010) $display("FAIL full_status: got %h want 2010", d); else n_pass++;
        n_chk++; if (interrupt !== 1'b0) $display("FAIL full_irq: got %b want 0", interrupt); else n_pass++;
        for (int k = 0; k < DEPTH; k++) begin
            apb_read(0, 4'h0, d);
            n_chk++; if (d !== exp_q[0]) $display("FAIL full_data[%0d]: got %h want %h", k, d, exp_q[0]); else n_pass++;
            void'(exp_q.pop_front());
        end
        apb_read(0, 4'h4, d);
        n_chk++; if (d !== 16'h1000) $display("FAIL full_drained: got %h want 1000", d); else n_pass++;
    endtask

    task automatic test_threshold();
        logic [15:0] d;
        fill_mic(4, 16'h0F0F, 4);
        apb_write(0, 4'h8, 16'h0403);
        for (int k = 0; k < 4; k++) begin
            wait_cs(1, 0, DIV + 20, "thr_start");
            wait_cs(1, 1, CS_LOW + 10, "thr_end");
        end
        n_chk++; if (interrupt !== 1'b0) $display("FAIL thr_pre: got %b want 0", interrupt); else n_pass++;
        @(posedge PCLK); #1;
        n_chk++; if (interrupt !== 1'b0) $display("FAIL thr_push_cycle: got %b want 0", interrupt); else n_pass++;
        @(posedge PCLK); #1;
        n_chk++; if (interrupt !== 1'b1) $display("FAIL thr_rise: got %b want 1", interrupt); else n_pass++;
        apb_write(0, 4'h8, 16'h0402);
        apb_read(0, 4'h0, d);
        n_chk++; if (d !== exp_q[0]) $display("FAIL thr_data0: got %h want %h", d, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        n_chk++; if (interrupt !== 1'b1) $display("FAIL thr_lag: got %b want 1", interrupt); else n_pass++;
        @(posedge PCLK); #1;
        n_chk++; if (interrupt !== 1'b0) $display("FAIL thr_drop: got %b want 0", interrupt); else n_pass++;
        for (int k = 1; k < 4; k++) begin
            apb_read(0, 4'h0, d);
            n_chk++; if (d !== exp_q[0]) $display("FAIL thr_data[%0d]: got %h want %h", k, d, exp_q[0]); else n_pass++;
            void'(exp_q.pop_front());
        end
        apb_write(0, 4'h8, 16'h0000);
    endtask

    task automatic test_signext();
        logic [15:0] d;
        apb_write(1, 4'h8, 16'h0001);
        wait_cs(0, 0, 150, "sx_start");
        wait_cs(0, 1, 100, "sx_end");
        apb_write(1, 4'h8, 16'h0000);
        apb_read(1, 4'h0, d);
        n_chk++; if (d !== ext(16'h0800, 12)) $display("FAIL signext_data: got %h want %h", d, ext(16'h0800, 12)); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mic_words[i] = 16'h0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 0;
        test_reset();
        test_frame();
        test_regs();
        test_overflow();
        test_full_push_pop();
        test_threshold();
        test_signext();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
